// File: rtl/space_inv_pkg.sv
// Shared types and default geometry for the space-invaders sprite blocks.
package space_inv_pkg;

    localparam int unsigned PIX_W = 11;
    localparam int unsigned SUM_W = 12;

    localparam int unsigned DEF_OBJECT_WIDTH_X  = 64;
    localparam int unsigned DEF_OBJECT_HEIGHT_Y = 64;
    localparam int unsigned DEF_INIT_X          = 288;
    localparam int unsigned DEF_INIT_Y          = 208;
    localparam int unsigned DEF_SPEED_X         = 2;
    localparam int unsigned DEF_X_MAX           = 639;
    localparam int unsigned DEF_BLINK_FRAMES    = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MOVE_RIGHT = 2'd1,
        MOVE_LEFT  = 2'd2
    } mv_state_t;

endpackage

// File: rtl/sprite_window_cmp.sv
// Combinational window test: is the pixel inside the sprite, and where within it.
module sprite_window_cmp
    import space_inv_pkg::*;
#(
    parameter int unsigned OBJECT_WIDTH_X  = DEF_OBJECT_WIDTH_X,
    parameter int unsigned OBJECT_HEIGHT_Y = DEF_OBJECT_HEIGHT_Y,
    parameter int unsigned TOP_Y           = DEF_INIT_Y
)(
    input  logic [PIX_W-1:0] pixel_x,
    input  logic [PIX_W-1:0] pixel_y,
    input  logic [PIX_W-1:0] top_left_x,
    output logic             inside_c,
    output logic [PIX_W-1:0] offset_x_c,
    output logic [PIX_W-1:0] offset_y_c
);

    localparam logic [SUM_W-1:0] TOP_Y_W    = SUM_W'(TOP_Y);
    localparam logic [SUM_W-1:0] BOTTOM_Y_W = SUM_W'(TOP_Y + OBJECT_HEIGHT_Y);

    logic [SUM_W-1:0] px_w;
    logic [SUM_W-1:0] py_w;
    logic [SUM_W-1:0] left_w;
    logic [SUM_W-1:0] right_w;
    logic             in_x;
    logic             in_y;

    // Bounds are evaluated one bit wider so right/bottom edges never wrap.
    assign px_w    = {1'b0, pixel_x};
    assign py_w    = {1'b0, pixel_y};
    assign left_w  = {1'b0, top_left_x};
    assign right_w = left_w + SUM_W'(OBJECT_WIDTH_X);

    assign in_x     = (px_w >= left_w) && (px_w < right_w);
    assign in_y     = (py_w >= TOP_Y_W) && (py_w < BOTTOM_Y_W);
    assign inside_c = in_x && in_y;

    assign offset_x_c = inside_c ? (pixel_x - top_left_x)     : '0;
    assign offset_y_c = inside_c ? (pixel_y - PIX_W'(TOP_Y))  : '0;

endmodule

// File: rtl/sprite_window_driver.sv
// Horizontally bouncing sprite: position FSM plus registered window/offset outputs.
// Optional blink feature enabled by defining SPRITE_WINDOW_BLINK_EN.
module sprite_window_driver
    import space_inv_pkg::*;
#(
    parameter int unsigned OBJECT_WIDTH_X  = DEF_OBJECT_WIDTH_X,
    parameter int unsigned OBJECT_HEIGHT_Y = DEF_OBJECT_HEIGHT_Y,
    parameter int unsigned INIT_X          = DEF_INIT_X,
    parameter int unsigned INIT_Y          = DEF_INIT_Y,
    parameter int unsigned SPEED_X         = DEF_SPEED_X,
    parameter int unsigned X_MAX           = DEF_X_MAX,
    parameter int unsigned BLINK_FRAMES    = DEF_BLINK_FRAMES
)(
    input  logic             clk,
    input  logic             resetN,
    input  logic [PIX_W-1:0] pixelX,
    input  logic [PIX_W-1:0] pixelY,
    input  logic             startOfFrame,
    input  logic             enable,
    output logic [PIX_W-1:0] offsetX,
    output logic [PIX_W-1:0] offsetY,
    output logic             InsideRectangle,
    output logic [PIX_W-1:0] topLeftX
);

    localparam logic [SUM_W-1:0] WIDTH_W     = SUM_W'(OBJECT_WIDTH_X);
    localparam logic [SUM_W-1:0] SPEED_W     = SUM_W'(SPEED_X);
    localparam logic [SUM_W-1:0] RIGHT_LIMIT = SUM_W'(X_MAX + 1);
    localparam logic [PIX_W-1:0] RIGHT_PARK  = PIX_W'(X_MAX + 1 - OBJECT_WIDTH_X);
    localparam logic [PIX_W-1:0] SPEED_P     = PIX_W'(SPEED_X);
    localparam logic [PIX_W-1:0] INIT_X_P    = PIX_W'(INIT_X);

    if (BLINK_FRAMES == 0 || OBJECT_WIDTH_X > X_MAX + 1) begin : g_param_check
        $error("sprite_window_driver: BLINK_FRAMES must be nonzero and sprite must fit in X_MAX");
    end

    mv_state_t        state;
    mv_state_t        state_nxt;
    logic [PIX_W-1:0] x_nxt;
    logic [SUM_W-1:0] right_edge_nxt;
    logic             sof_d;
    logic             sof_rise;
    logic             visible;
    logic             inside_c;
    logic [PIX_W-1:0] offset_x_c;
    logic [PIX_W-1:0] offset_y_c;

    // Long startOfFrame pulses still produce only one step.
    assign sof_rise = startOfFrame & ~sof_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            sof_d <= 1'b0;
        end else begin
            sof_d <= startOfFrame;
        end
    end

    // State and position register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            topLeftX <= INIT_X_P;
        end else begin
            state    <= state_nxt;
            topLeftX <= x_nxt;
        end
    end

    // Next-state and next-position logic; moves only on a frame edge.
    always_comb begin
        state_nxt      = state;
        x_nxt          = topLeftX;
        right_edge_nxt = {1'b0, topLeftX} + WIDTH_W + SPEED_W;
        if (sof_rise) begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state_nxt = MOVE_RIGHT;
                    end
                end
                MOVE_RIGHT: begin
                    if (!enable) begin
                        state_nxt = IDLE;
                    end else if (right_edge_nxt > RIGHT_LIMIT) begin
                        x_nxt     = RIGHT_PARK;
                        state_nxt = MOVE_LEFT;
                    end else begin
                        x_nxt = topLeftX + SPEED_P;
                    end
                end
                MOVE_LEFT: begin
                    if (!enable) begin
                        state_nxt = IDLE;
                    end else if (topLeftX < SPEED_P) begin
                        x_nxt     = '0;
                        state_nxt = MOVE_RIGHT;
                    end else begin
                        x_nxt = topLeftX - SPEED_P;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

`ifdef SPRITE_WINDOW_BLINK_EN
    localparam int unsigned BLINK_CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BLINK_CNT_W-1:0] blink_cnt;

    // Frame counter toggles visibility every BLINK_FRAMES edges, independent of enable.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt <= '0;
            visible   <= 1'b1;
        end else if (sof_rise) begin
            if (blink_cnt == BLINK_CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt <= '0;
                visible   <= ~visible;
            end else begin
                blink_cnt <= blink_cnt + BLINK_CNT_W'(1);
            end
        end
    end
`else
    assign visible = 1'b1;
`endif

    sprite_window_cmp #(
        .OBJECT_WIDTH_X  (OBJECT_WIDTH_X),
        .OBJECT_HEIGHT_Y (OBJECT_HEIGHT_Y),
        .TOP_Y           (INIT_Y)
    ) u_cmp (
        .pixel_x    (pixelX),
        .pixel_y    (pixelY),
        .top_left_x (topLeftX),
        .inside_c   (inside_c),
        .offset_x_c (offset_x_c),
        .offset_y_c (offset_y_c)
    );

    // Window outputs lag the pixel coordinates by one clock.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            InsideRectangle <= inside_c & visible;
            offsetX         <= visible ? offset_x_c : '0;
            offsetY         <= visible ? offset_y_c : '0;
        end
    end

endmodule

// File: tb/tb_sprite_window_driver.sv
// Scoreboard bench for sprite_window_driver: window geometry, bounce FSM, reset, optional blink.
module tb_sprite_window_driver;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [10:0] pixelX = 11'd300;
    logic [10:0] pixelY = 11'd220;
    logic        startOfFrame = 1'b0;
    logic        enable = 1'b0;

    logic [10:0] a_ox, a_oy, a_tlx;
    logic        a_in;
    logic [10:0] b_ox, b_oy, b_tlx;
    logic        b_in;
    logic [10:0] c_ox, c_oy, c_tlx;
    logic        c_in;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        in_a;
        logic [10:0] ox_a;
        logic [10:0] oy_a;
        logic [10:0] tlx_a;
        bit          chk_b;
        logic [10:0] tlx_b;
        bit          chk_c;
        logic        in_c;
        logic [10:0] ox_c;
        logic [10:0] oy_c;
    } exp_t;

    exp_t sb_q[$];
    logic chk_en = 1'b0;
    logic chk_d  = 1'b0;

    always #5 clk = ~clk;

    // Default geometry; blink period long enough never to trigger here.
    sprite_window_driver #(.BLINK_FRAMES(4096)) dut_a (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .enable(enable),
        .offsetX(a_ox), .offsetY(a_oy), .InsideRectangle(a_in), .topLeftX(a_tlx));

    // Narrow playfield so both bounce limits are reached in a few frames.
    sprite_window_driver #(.INIT_X(3), .X_MAX(70), .BLINK_FRAMES(4096)) dut_b (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .enable(enable),
        .offsetX(b_ox), .offsetY(b_oy), .InsideRectangle(b_in), .topLeftX(b_tlx));

    sprite_window_driver #(.BLINK_FRAMES(2)) dut_c (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .enable(enable),
        .offsetX(c_ox), .offsetY(c_oy), .InsideRectangle(c_in), .topLeftX(c_tlx));

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // c_mode: 0 = do not check dut_c, 1 = visible, 2 = hidden
    task automatic chk(input int px, input int py, input logic in, input int ox, input int oy,
                       input int tlx, input bit chk_b, input int tlx_b, input int c_mode);
        exp_t e;
        @(negedge clk);
        pixelX  = 11'(px);
        pixelY  = 11'(py);
        e.in_a  = in;
        e.ox_a  = 11'(ox);
        e.oy_a  = 11'(oy);
        e.tlx_a = 11'(tlx);
        e.chk_b = chk_b;
        e.tlx_b = 11'(tlx_b);
        e.chk_c = (c_mode != 0);
        e.in_c  = (c_mode == 1) ? in : 1'b0;
        e.ox_c  = (c_mode == 1) ? 11'(ox) : 11'd0;
        e.oy_c  = (c_mode == 1) ? 11'(oy) : 11'd0;
        sb_q.push_back(e);
        chk_en = 1'b1;
        @(negedge clk);
        chk_en = 1'b0;
    endtask

    task automatic sof(input int n);
        @(negedge clk);
        startOfFrame = 1'b1;
        repeat (n - 1) @(negedge clk);
        @(negedge clk);
        startOfFrame = 1'b0;
        @(negedge clk);
    endtask

    always @(posedge clk) chk_d <= chk_en;

    // Monitor: one clock after a pixel is presented, compare registered outputs.
    always @(negedge clk) begin
        if (chk_d) begin
            if (sb_q.size() == 0) begin
                cmp("sb_underflow", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                cmp("a_inside", 32'(a_in), 32'(e.in_a));
                cmp("a_offsetX", 32'(a_ox), 32'(e.ox_a));
                cmp("a_offsetY", 32'(a_oy), 32'(e.oy_a));
                cmp("a_topLeftX", 32'(a_tlx), 32'(e.tlx_a));
                if (e.chk_b) cmp("b_topLeftX", 32'(b_tlx), 32'(e.tlx_b));
`ifdef SPRITE_WINDOW_BLINK_EN
                if (e.chk_c) begin
                    cmp("c_inside", 32'(c_in), 32'(e.in_c));
                    cmp("c_offsetX", 32'(c_ox), 32'(e.ox_c));
                    cmp("c_offsetY", 32'(c_oy), 32'(e.oy_c));
                end
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Outputs held at reset values while resetN is low.
        #12;
        cmp("rst_inside", 32'(a_in), 32'd0);
        cmp("rst_offsetX", 32'(a_ox), 32'd0);
        cmp("rst_offsetY", 32'(a_oy), 32'd0);
        cmp("rst_topLeftX", 32'(a_tlx), 32'd288);
        cmp("rst_b_topLeftX", 32'(b_tlx), 32'd3);
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        chk(300, 220, 1, 12, 12, 288, 1, 3, 1);
        // Blink: frames 0-1 visible, 2-3 hidden, 4 visible again.
        sof(1); chk(300, 220, 1, 12, 12, 288, 1, 3, 1);
        sof(1); chk(300, 220, 1, 12, 12, 288, 1, 3, 2);
        sof(1); chk(300, 220, 1, 12, 12, 288, 1, 3, 2);
        sof(1); chk(300, 220, 1, 12, 12, 288, 1, 3, 1);

        // Window edges with topLeftX=288, top Y=208.
        chk(352, 220, 0, 0, 0, 288, 1, 3, 1);
        chk(351, 220, 1, 63, 12, 288, 1, 3, 1);
        chk(287, 220, 0, 0, 0, 288, 1, 3, 1);
        chk(288, 208, 1, 0, 0, 288, 1, 3, 1);
        chk(300, 207, 0, 0, 0, 288, 1, 3, 1);
        chk(300, 271, 1, 12, 63, 288, 1, 3, 1);
        chk(300, 272, 0, 0, 0, 288, 1, 3, 1);
        chk(2047, 2047, 0, 0, 0, 288, 1, 3, 0);

        // Motion: first edge only leaves IDLE.
        enable = 1'b1;
        sof(1); chk(0, 0, 0, 0, 0, 288, 1, 3, 0);
        sof(1); chk(0, 0, 0, 0, 0, 290, 1, 5, 0);
        sof(1); chk(0, 0, 0, 0, 0, 292, 1, 7, 0);
        chk(355, 220, 1, 63, 12, 292, 1, 7, 0);
        chk(356, 220, 0, 0, 0, 292, 1, 7, 0);
        sof(1); chk(0, 0, 0, 0, 0, 294, 1, 7, 0);   // b parks at 71-64, turns left
        sof(1); chk(0, 0, 0, 0, 0, 296, 1, 5, 0);
        sof(1); chk(0, 0, 0, 0, 0, 298, 1, 3, 0);
        sof(1); chk(0, 0, 0, 0, 0, 300, 1, 1, 0);
        sof(1); chk(0, 0, 0, 0, 0, 302, 1, 0, 0);   // b below SPEED_X: clamps to 0, turns right
        sof(1); chk(0, 0, 0, 0, 0, 304, 1, 2, 0);

        for (int i = 0; i < 135; i++) sof(1);
        chk(0, 0, 0, 0, 0, 574, 0, 0, 0);
        sof(1); chk(0, 0, 0, 0, 0, 576, 0, 0, 0);
        sof(1); chk(0, 0, 0, 0, 0, 576, 0, 0, 0);   // 576+64+2 > 640: park and turn left
        sof(1); chk(0, 0, 0, 0, 0, 574, 0, 0, 0);
        sof(1); chk(0, 0, 0, 0, 0, 572, 0, 0, 0);

        // Disable during MOVE_LEFT; resume goes right.
        enable = 1'b0;
        sof(1); chk(0, 0, 0, 0, 0, 572, 0, 0, 0);
        sof(1); chk(0, 0, 0, 0, 0, 572, 0, 0, 0);
        enable = 1'b1;
        sof(1); chk(0, 0, 0, 0, 0, 572, 0, 0, 0);
        sof(1); chk(0, 0, 0, 0, 0, 574, 0, 0, 0);
        sof(4); chk(0, 0, 0, 0, 0, 576, 0, 0, 0);
        chk(600, 220, 1, 24, 12, 576, 0, 0, 0);

        // Reset in the middle of a frame pulse.
        @(negedge clk);
        startOfFrame = 1'b1;
        #2 resetN = 1'b0;
        #1;
        cmp("midrst_inside", 32'(a_in), 32'd0);
        cmp("midrst_offsetX", 32'(a_ox), 32'd0);
        cmp("midrst_offsetY", 32'(a_oy), 32'd0);
        cmp("midrst_topLeftX", 32'(a_tlx), 32'd288);
        cmp("midrst_b_topLeftX", 32'(b_tlx), 32'd3);
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        chk(300, 220, 1, 12, 12, 288, 1, 3, 1);
        startOfFrame = 1'b0;
        sof(1); chk(0, 0, 0, 0, 0, 290, 1, 5, 0);

        repeat (3) @(negedge clk);
        cmp("sb_leftover", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
